// File: rtl/digit_serial_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
//   addsub_state_t : controller state encoding (IDLE, RUN, DONE)
//   cnt_width()    : digit counter width, clog2(WIDTH/DIGIT) with a floor of 1
//   cfg_ok()       : legality of a WIDTH/DIGIT pair, evaluated at elaboration
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addsub_state_t;

    function automatic int cnt_width(input int width, input int digit);
        int n;
        if (digit < 1) return 1;
        n = width / digit;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit cfg_ok(input int width, input int digit);
        return (digit >= 1) && (width >= digit) && ((width % digit) == 0);
    endfunction

endpackage

// File: rtl/digit_serial_addsub_if.sv
// Operand/result handshake bundle for digit_serial_addsub.
//   master : drives operands (in_valid, a, b, sub) and out_ready
//   slave  : the adder; drives in_ready and the registered result
//            (out_valid, sum, cout, ovf, zero)
interface digit_serial_addsub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/digit_serial_addsub_ripple_chunk.sv
// Combinational DIGIT-bit ripple-carry adder built from full-adder cells.
//   a, b   : DIGIT-bit addends
//   cin    : carry into bit 0
//   s      : DIGIT-bit sum
//   cout   : carry out of the top bit
//   c_msb  : carry into the top bit (xor with cout gives signed overflow)
module ripple_chunk #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    // Each cell owns its carry-in/carry-out so the chain is a set of
    // distinct nets rather than one self-referencing vector.
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        logic ci;
        logic co;
        if (i == 0) begin : g_first
            assign ci = cin;
        end else begin : g_next
            assign ci = g_fa[i-1].co;
        end
        assign s[i] = a[i] ^ b[i] ^ ci;
        assign co   = (a[i] & b[i]) | (ci & (a[i] ^ b[i]));
    end

    assign cout  = g_fa[DIGIT-1].co;
    assign c_msb = g_fa[DIGIT-1].ci;

endmodule

// File: rtl/digit_serial_addsub.sv
// Digit-serial two's-complement adder/subtractor. One DIGIT-wide ripple
// chunk is reused over WIDTH/DIGIT clocks with the carry held in a register.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : slave side of digit_serial_addsub_if (operands in via
//              in_valid/in_ready, registered result out via out_valid/out_ready)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready high; waiting for operands
// RUN   | one digit per clock, LSB digit first, result shifts in from top
// DONE  | out_valid high; result held until out_ready
module digit_serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    digit_serial_addsub_if.slave bus
);

    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int CW         = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST_DIGIT = CW'(NUM_DIGITS - 1);

    if (!cfg_ok(WIDTH, DIGIT)) begin : g_cfg_err
        $error("digit_serial_addsub: WIDTH must be a positive multiple of DIGIT");
    end

    addsub_state_t    state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] sum_r;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;

    logic [DIGIT-1:0] chunk_s;
    logic             chunk_cout;
    logic             chunk_cmsb;
    logic [WIDTH-1:0] sum_next;

    ripple_chunk #(.DIGIT(DIGIT)) u_chunk (
        .a     (op_a[DIGIT-1:0]),
        .b     (op_b[DIGIT-1:0]),
        .cin   (carry),
        .s     (chunk_s),
        .cout  (chunk_cout),
        .c_msb (chunk_cmsb)
    );

    // New digit enters at the top; after NUM_DIGITS shifts the first digit
    // has reached bit 0. Written as a shift so DIGIT == WIDTH needs no
    // special case.
    assign sum_next = WIDTH'({chunk_s, sum_r} >> DIGIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            sum_r       <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        // Subtraction as A + ~B + 1: the +1 rides in on the
                        // initial carry, so sub needs no separate register.
                        op_a       <= bus.a;
                        op_b       <= bus.b ^ {WIDTH{bus.sub}};
                        carry      <= bus.sub;
                        cnt        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> DIGIT;
                    op_b  <= op_b >> DIGIT;
                    sum_r <= sum_next;
                    carry <= chunk_cout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST_DIGIT) begin
                        cout_r      <= chunk_cout;
                        ovf_r       <= chunk_cmsb ^ chunk_cout;
                        zero_r      <= (sum_next == '0);
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
    assign bus.zero      = zero_r;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Scoreboard bench for digit_serial_addsub: three instances (DIGIT = 4, 16, 1)
// at WIDTH = 16. Stimulus pushes expected results; a negedge monitor compares
// whenever an instance shows out_valid and pops on the handshake.
module tb_digit_serial_addsub;
    localparam int W    = 16;
    localparam int NDUT = 3;

    typedef struct {
        int           g;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NDUT-1:0] in_valid_d;
    logic [NDUT-1:0] sub_d;
    logic [NDUT-1:0] out_ready_d;
    logic [W-1:0]    a_d [NDUT];
    logic [W-1:0]    b_d [NDUT];
    logic [NDUT-1:0] in_ready_o;
    logic [NDUT-1:0] out_valid_o;
    logic [NDUT-1:0] cout_o;
    logic [NDUT-1:0] ovf_o;
    logic [NDUT-1:0] zero_o;
    logic [W-1:0]    sum_o [NDUT];

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int D = (g == 0) ? 4 : ((g == 1) ? W : 1);
        digit_serial_addsub_if #(.WIDTH(W)) bus ();
        assign bus.in_valid   = in_valid_d[g];
        assign bus.a          = a_d[g];
        assign bus.b          = b_d[g];
        assign bus.sub        = sub_d[g];
        assign bus.out_ready  = out_ready_d[g];
        assign in_ready_o[g]  = bus.in_ready;
        assign out_valid_o[g] = bus.out_valid;
        assign sum_o[g]       = bus.sum;
        assign cout_o[g]      = bus.cout;
        assign ovf_o[g]       = bus.ovf;
        assign zero_o[g]      = bus.zero;
        digit_serial_addsub #(.WIDTH(W), .DIGIT(D)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    function automatic int ndig(input int g);
        return (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    // Independent reference: plain integer add/sub with sign-rule overflow.
    function automatic exp_t model(input int g, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s);
        logic [W:0] r;
        exp_t       e;
        r      = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        e.g    = g;
        e.sum  = r[W-1:0];
        e.cout = s ? (a >= b) : r[W];
        e.ovf  = s ? ((a[W-1] != b[W-1]) && (e.sum[W-1] != a[W-1]))
                   : ((a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]));
        e.zero = (e.sum == '0);
        return e;
    endfunction

    always @(negedge clk) begin
        for (int g = 0; g < NDUT; g++) begin
            if (rst === 1'b0 && out_valid_o[g] === 1'b1) begin
                if (exp_q.size() == 0 || exp_q[0].g != g) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result dut%0d: got sum %0h, want no result", g, sum_o[g]);
                end else begin
                    check($sformatf("result dut%0d {sum,cout,ovf,zero}", g),
                          {sum_o[g], cout_o[g], ovf_o[g], zero_o[g]},
                          {exp_q[0].sum, exp_q[0].cout, exp_q[0].ovf, exp_q[0].zero});
                    if (out_ready_d[g]) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic run_op(input int g, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input exp_t e, input int hold, input bit junk);
        int n_wait;
        int lat;
        int guard;
        n_wait = 0;
        while (in_ready_o[g] !== 1'b1 && n_wait < 50) begin
            @(posedge clk); #1;
            n_wait++;
        end
        check($sformatf("in_ready_before_accept dut%0d", g), in_ready_o[g], 1);
        a_d[g]         = a;
        b_d[g]         = b;
        sub_d[g]       = s;
        in_valid_d[g]  = 1'b1;
        out_ready_d[g] = (hold == 0);
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid_d[g] = 1'b0;
        a_d[g]        = W'($urandom);
        b_d[g]        = W'($urandom);
        sub_d[g]      = 1'($urandom);
        lat = 0;
        while (out_valid_o[g] !== 1'b1 && lat < 64) begin
            if (junk) begin
                check("in_ready_low_in_run", in_ready_o[g], 0);
                in_valid_d[g] = ~in_valid_d[g];
                a_d[g]        = W'($urandom);
                b_d[g]        = W'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("latency dut%0d", g), lat, ndig(g));
        check($sformatf("in_ready_low_in_done dut%0d", g), in_ready_o[g], 0);
        for (int k = 0; k < hold; k++) begin
            if (junk) begin
                check("in_ready_low_in_done_held", in_ready_o[g], 0);
                in_valid_d[g] = ~in_valid_d[g];
                a_d[g]        = W'($urandom);
                b_d[g]        = W'($urandom);
            end
            @(posedge clk); #1;
        end
        in_valid_d[g]  = 1'b0;
        out_ready_d[g] = 1'b1;
        guard = 0;
        while (out_valid_o[g] === 1'b1 && guard < 4) begin
            @(posedge clk); #1;
            guard++;
        end
        check($sformatf("handshake_edges dut%0d", g), guard, 1);
        check($sformatf("in_ready_after_handshake dut%0d", g), in_ready_o[g], 1);
        out_ready_d[g] = 1'b0;
    endtask

    vec_t vecs [10];

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rs;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[8] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};

        in_valid_d  = '0;
        sub_d       = '0;
        out_ready_d = '0;
        for (int g = 0; g < NDUT; g++) begin
            a_d[g] = '0;
            b_d[g] = '0;
        end

        rst = 1'b1;
        @(posedge clk); #1;
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("reset in_ready dut%0d", g), in_ready_o[g], 1);
            check($sformatf("reset {out_valid,sum,cout,ovf,zero} dut%0d", g),
                  {out_valid_o[g], sum_o[g], cout_o[g], ovf_o[g], zero_o[g]}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // DIGIT=4: directed vectors, then back-pressure with junk inputs.
        for (int i = 0; i < 5; i++) begin
            e = '{0, vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero};
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].s, e, 0, 1'b0);
        end
        e = '{0, 16'h0B0D, 1'b0, 1'b0, 1'b0};
        run_op(0, 16'h0A0B, 16'h0102, 1'b0, e, 5, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        check("no_second_capture out_valid", out_valid_o[0], 0);
        check("no_second_capture in_ready", in_ready_o[0], 1);

        // Reset landing on the second RUN edge of 0x1111+0x2222.
        a_d[0]         = 16'h1111;
        b_d[0]         = 16'h2222;
        sub_d[0]       = 1'b0;
        in_valid_d[0]  = 1'b1;
        out_ready_d[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_d[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort in_ready", in_ready_o[0], 1);
        check("abort {out_valid,sum,cout,ovf,zero}",
              {out_valid_o[0], sum_o[0], cout_o[0], ovf_o[0], zero_o[0]}, 0);
        repeat (6) @(posedge clk);
        #1;
        check("abort no late result", out_valid_o[0], 0);
        out_ready_d[0] = 1'b0;

        for (int i = 5; i < 10; i++) begin
            e = '{0, vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero};
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].s, e, 0, 1'b0);
        end

        // DIGIT=16 and DIGIT=1: same directed table, then model-checked random.
        for (int g = 1; g < NDUT; g++) begin
            for (int i = 0; i < 10; i++) begin
                e = '{g, vecs[i].sum, vecs[i].cout, vecs[i].ovf, vecs[i].zero};
                run_op(g, vecs[i].a, vecs[i].b, vecs[i].s, e, 0, 1'b0);
            end
        end
        for (int g = 0; g < NDUT; g++) begin
            for (int i = 0; i < 6; i++) begin
                ra = W'($urandom);
                rb = W'($urandom);
                rs = 1'($urandom);
                run_op(g, ra, rb, rs, model(g, ra, rb, rs), i % 3, 1'b0);
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
